// File: rtl/mmio_timer_if.sv
// Data-bus link between the processor and the memory-mapped timer.
interface mmio_timer_if #(
    parameter int unsigned N = 16
) ();
    logic [15:0]  addr;
    logic [N-1:0] data_in;
    logic         write;
    logic         sel;
    logic [N-1:0] rd_data;
    logic         irq;

    modport master (
        output addr,
        output data_in,
        output write,
        input  sel,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write,
        output sel,
        output rd_data,
        output irq
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled countdown timer with one-shot/auto-reload modes,
// sticky expiry flag and interrupt output.
module mmio_timer #(
    parameter logic [3:0]  BASE     = 4'h3,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned n        = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    mmio_timer_if.slave   bus
);

    localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_AR  = 1;
    localparam int unsigned CTRL_IRQ = 2;

    logic [n-1:0]  load_q,    load_d;
    logic [n-1:0]  count_q,   count_d;
    logic [2:0]    ctrl_q,    ctrl_d;
    logic          expired_q, expired_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [1:0]    state_q,   state_d;
    logic [n-1:0]  rd_q,      rd_d;

    logic [1:0]    reg_idx;
    logic          wr_en;
    logic          tick;
    logic          unused_addr;

    // Region decode; the map aliases across addr[11:2].
    assign bus.sel     = (bus.addr[15:12] == BASE);
    assign reg_idx     = bus.addr[1:0];
    assign wr_en       = bus.write & bus.sel;
    assign unused_addr = ^bus.addr[11:2];

    // One tick per PRESCALE cycles while counting.
    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

    // State registers, synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            load_q    <= '0;
            count_q   <= '0;
            ctrl_q    <= '0;
            expired_q <= 1'b0;
            presc_q   <= '0;
            state_q   <= IDLE;
            rd_q      <= '0;
        end else begin
            load_q    <= load_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            rd_q      <= rd_d;
        end
    end

    // Next-state: bus writes to LOAD/CTRL take priority over a tick.
    always_comb begin
        load_d    = load_q;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        expired_d = expired_q;
        state_d   = state_q;
        presc_d   = '0;

        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // W1C first so that an expiry on the same edge keeps the flag set.
        if (wr_en && (reg_idx == REG_STATUS) && bus.data_in[0]) begin
            expired_d = 1'b0;
        end

        if (wr_en && (reg_idx == REG_LOAD)) begin
            load_d  = bus.data_in;
            count_d = bus.data_in;
            presc_d = '0;
            if (ctrl_q[CTRL_EN]) begin
                state_d = (bus.data_in != '0) ? RUN : HALT;
            end else begin
                state_d = IDLE;
            end
        end else if (wr_en && (reg_idx == REG_CTRL)) begin
            ctrl_d  = bus.data_in[2:0];
            presc_d = '0;
            if (bus.data_in[CTRL_EN]) begin
                state_d = (count_q != '0) ? RUN : HALT;
            end else begin
                state_d = IDLE;
            end
        end else if (tick) begin
            if (count_q == n'(1)) begin
                expired_d = 1'b1;
                if (ctrl_q[CTRL_AR] && (load_q != '0)) begin
                    count_d = load_q;
                    state_d = RUN;
                end else if (ctrl_q[CTRL_AR]) begin
                    count_d = '0;
                    state_d = HALT;
                end else begin
                    count_d         = '0;
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = IDLE;
                end
            end else if (count_q != '0) begin
                count_d = count_q - n'(1);
            end
        end
    end

    // Read mux; registered one cycle behind the address, zero when unselected.
    always_comb begin
        rd_d = '0;
        if (bus.sel) begin
            case (reg_idx)
                REG_LOAD:   rd_d = load_q;
                REG_COUNT:  rd_d = count_q;
                REG_CTRL:   rd_d = n'(ctrl_q);
                REG_STATUS: rd_d = n'(expired_q);
            endcase
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.irq     = expired_q & ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer with a read-expectation queue.
module tb_mmio_timer;

    localparam logic [15:0] A_LOAD   = 16'h3000;
    localparam logic [15:0] A_COUNT  = 16'h3001;
    localparam logic [15:0] A_CTRL   = 16'h3002;
    localparam logic [15:0] A_STATUS = 16'h3003;

    logic Clock = 1'b0;
    logic Resetn;

    always #5 Clock = ~Clock;

    mmio_timer_if #(.N(16)) bus ();

    mmio_timer #(
        .BASE     (4'h3),
        .PRESCALE (4),
        .n        (16)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write strobe on the next posedge; returns on the following negedge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus.write   = 1'b1;
        @(negedge Clock);
        bus.write   = 1'b0;
    endtask

    // Queue the expected read value, then check rd_data after the edge.
    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        sb_t e;
        bus.addr  = a;
        bus.write = 1'b0;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        compare(e.tag, bus.rd_data, e.exp);
        @(negedge Clock);
    endtask

    task automatic nop(input int k);
        repeat (k) @(negedge Clock);
    endtask

    initial begin
        Resetn      = 1'b0;
        bus.addr    = A_CTRL;
        bus.data_in = 16'hFFFF;
        bus.write   = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        compare("rst_rd_data", bus.rd_data, 16'h0000);
        compare("rst_irq", 16'(bus.irq), 16'h0000);
        @(negedge Clock);
        Resetn    = 1'b1;
        bus.write = 1'b0;
        rd(A_LOAD,   16'h0000, "rst_load");
        rd(A_COUNT,  16'h0000, "rst_count");
        rd(A_CTRL,   16'h0000, "rst_ctrl");
        rd(A_STATUS, 16'h0000, "rst_status");

        // One-shot: CTRL write is edge 0, expiry lands on edge 12.
        wr(A_LOAD, 16'h0003);
        wr(A_CTRL, 16'h0005);
        rd(A_COUNT, 16'h0003, "os_count3");
        nop(3);
        rd(A_COUNT, 16'h0002, "os_count2");
        nop(3);
        rd(A_COUNT, 16'h0001, "os_count1");
        nop(2);
        compare("os_irq_before", 16'(bus.irq), 16'h0000);
        rd(A_STATUS, 16'h0000, "os_status_before");
        compare("os_irq_at12", 16'(bus.irq), 16'h0001);
        rd(A_STATUS, 16'h0001, "os_status_at12");
        rd(A_COUNT,  16'h0000, "os_count0");
        rd(A_CTRL,   16'h0004, "os_ctrl_after");
        nop(8);
        rd(A_COUNT,  16'h0000, "os_count_held");
        wr(A_STATUS, 16'h0001);
        compare("os_irq_cleared", 16'(bus.irq), 16'h0000);

        // Auto-reload: expiries on edges 8, 16, 24.
        wr(A_LOAD, 16'h0002);
        wr(A_CTRL, 16'h0003);
        rd(A_COUNT,  16'h0002, "ar_count2");
        nop(3);
        rd(A_COUNT,  16'h0001, "ar_count1");
        nop(2);
        rd(A_STATUS, 16'h0000, "ar_status_e7");
        rd(A_STATUS, 16'h0001, "ar_status_e8");
        rd(A_COUNT,  16'h0002, "ar_reloaded");
        wr(A_STATUS, 16'h0001);
        rd(A_STATUS, 16'h0000, "ar_w1c");
        rd(A_COUNT,  16'h0001, "ar_count1b");
        nop(2);
        rd(A_STATUS, 16'h0000, "ar_status_e15");
        rd(A_STATUS, 16'h0001, "ar_status_e16");
        compare("ar_irq_masked", 16'(bus.irq), 16'h0000);

        // Collision: W1C on the expiry edge 24 leaves the flag set.
        wr(A_STATUS, 16'h0001);
        nop(5);
        wr(A_STATUS, 16'h0001);
        rd(A_STATUS, 16'h0001, "col_w1c_vs_expiry");

        // Collision: LOAD on tick edge 28 wins, then counting resumes.
        nop(2);
        wr(A_LOAD, 16'h0005);
        rd(A_COUNT, 16'h0005, "col_load_on_tick");
        nop(2);
        rd(A_COUNT, 16'h0005, "col_load_hold");
        rd(A_COUNT, 16'h0004, "col_load_next_tick");

        // COUNT writes are ignored, including on tick edge 36.
        nop(1);
        wr(A_COUNT, 16'h00AA);
        wr(A_COUNT, 16'h0055);
        rd(A_COUNT, 16'h0003, "dec_count_write");
        rd(A_LOAD,  16'h0005, "dec_load_kept");

        // Writes outside the region have no effect and read as 0.
        bus.addr = 16'h0003;
        #1;
        compare("dec_sel_low", 16'(bus.sel), 16'h0000);
        bus.addr = A_STATUS;
        #1;
        compare("dec_sel_high", 16'(bus.sel), 16'h0001);
        wr(16'h0003, 16'h0001);
        wr(16'h0000, 16'h0009);
        wr(16'h0002, 16'h0000);
        rd(16'h0001, 16'h0000, "dec_unsel_rd");
        rd(A_STATUS, 16'h0001, "dec_status_kept");
        rd(A_LOAD,   16'h0005, "dec_load_kept2");
        rd(A_CTRL,   16'h0003, "dec_ctrl_kept");

        // Aliased CTRL access.
        wr(16'h3FF6, 16'h0006);
        compare("alias_irq", 16'(bus.irq), 16'h0001);
        rd(A_CTRL,   16'h0006, "alias_ctrl");
        rd(16'h3FF6, 16'h0006, "alias_rd");
        wr(A_STATUS, 16'h0000);
        rd(A_STATUS, 16'h0001, "w1c_zero");
        wr(A_STATUS, 16'h0001);
        compare("w1c_irq", 16'(bus.irq), 16'h0000);
        rd(A_STATUS, 16'h0000, "w1c_one");

        // Reset while running with COUNT=7.
        wr(A_LOAD, 16'h0007);
        wr(A_CTRL, 16'h0005);
        rd(A_COUNT, 16'h0007, "mid_count7");
        Resetn = 1'b0;
        wr(A_CTRL, 16'h0005);
        Resetn = 1'b1;
        compare("mid_rd_data", bus.rd_data, 16'h0000);
        compare("mid_irq", 16'(bus.irq), 16'h0000);
        rd(A_LOAD,   16'h0000, "mid_load");
        rd(A_COUNT,  16'h0000, "mid_count");
        rd(A_CTRL,   16'h0000, "mid_ctrl");
        rd(A_STATUS, 16'h0000, "mid_status");
        nop(8);
        rd(A_COUNT,  16'h0000, "mid_idle_count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
